// File: rtl/sampler_pkg.sv
// Shared types and default constants for the rejection-sampling coefficient generator.
package sampler_pkg;

    typedef enum logic [2:0] {IDLE, REQ, CHK, OUT, DONE} sampler_state_e;

    localparam int DEF_Q       = 8380417;
    localparam int DEF_QBITS   = 23;
    localparam int DEF_N       = 256;
    localparam int DEF_MAX_REJ = 64;

    // The per-run reject counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rand_coeff_sampler_if.sv
// Control, random-source and coefficient-stream signals of the sampler, bundled.
interface rand_coeff_sampler_if #(
    parameter int QBITS = 23,
    parameter int N     = 256
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic                   start;
    logic                   clear;
    logic                   rand_en;
    logic signed [31:0]     rand_num;
    logic [QBITS-1:0]       coeff;
    logic [IDXW-1:0]        coeff_idx;
    logic                   coeff_last;
    logic                   coeff_valid;
    logic                   coeff_ready;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [15:0]            reject_cnt;

    // The sampler itself.
    modport master (
        input  start, clear, rand_num, coeff_ready,
        output rand_en, coeff, coeff_idx, coeff_last, coeff_valid,
               busy, done, err, reject_cnt
    );

    // Controller, random source and coefficient consumer.
    modport slave (
        output start, clear, rand_num, coeff_ready,
        input  rand_en, coeff, coeff_idx, coeff_last, coeff_valid,
               busy, done, err, reject_cnt
    );

endinterface

// File: rtl/rand_coeff_sampler.sv
// Pulls random words one at a time and rejection-samples N coefficients in [0, Q),
// streaming each accepted value with its index before asking for the next word.
module rand_coeff_sampler
    import sampler_pkg::*;
#(
    parameter int Q       = DEF_Q,
    parameter int QBITS   = DEF_QBITS,
    parameter int N       = DEF_N,
    parameter int MAX_REJ = DEF_MAX_REJ
) (
    input  logic                 clk,
    input  logic                 rst,
    rand_coeff_sampler_if.master bus
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = $clog2(MAX_REJ + 1);

    localparam logic [QBITS-1:0] Q_W       = QBITS'(Q);
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(N - 1);
    localparam logic [CW-1:0]    MAX_REJ_W = CW'(MAX_REJ);

    generate
        if ((Q <= 0) || (longint'(Q) >= (longint'(1) << QBITS))) begin : g_bad_q
            $error("rand_coeff_sampler: Q must be positive and fit in QBITS bits");
        end
        if (MAX_REJ < 1) begin : g_bad_max_rej
            $error("rand_coeff_sampler: MAX_REJ must be at least 1");
        end
        // Only the low QBITS bits of the random word form the candidate.
        if (QBITS < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^bus.rand_num[31:QBITS];
        end
    endgenerate

    sampler_state_e   state_reg;
    logic             rand_en_reg;
    logic [QBITS-1:0] coeff_reg;
    logic [IDXW-1:0]  idx_reg;
    logic             last_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic [15:0]      rej_reg;
    logic [CW-1:0]    consec_reg;

    logic [QBITS-1:0] cand;
    logic [CW-1:0]    consec_next;

    // Raw low bits, sign of the 32-bit word deliberately ignored; compare is unsigned.
    assign cand        = bus.rand_num[QBITS-1:0];
    assign consec_next = consec_reg + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rand_en_reg <= 1'b0;
            coeff_reg   <= '0;
            idx_reg     <= '0;
            last_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            rej_reg     <= '0;
            consec_reg  <= '0;
        end else if (bus.clear) begin
            // Abort wins over start and every transition; err and reject_cnt survive.
            state_reg   <= IDLE;
            rand_en_reg <= 1'b0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            consec_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        state_reg   <= REQ;
                        rand_en_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        err_reg     <= 1'b0;
                        rej_reg     <= '0;
                        idx_reg     <= '0;
                        consec_reg  <= '0;
                    end
                end

                REQ: begin
                    rand_en_reg <= 1'b0;
                    state_reg   <= CHK;
                end

                CHK: begin
                    if (cand < Q_W) begin
                        state_reg  <= OUT;
                        coeff_reg  <= cand;
                        valid_reg  <= 1'b1;
                        last_reg   <= (idx_reg == LAST_IDX);
                        consec_reg <= '0;
                    end else begin
                        rej_reg    <= sat_inc16(rej_reg);
                        consec_reg <= consec_next;
                        if (consec_next == MAX_REJ_W) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                        end else begin
                            state_reg   <= REQ;
                            rand_en_reg <= 1'b1;
                        end
                    end
                end

                OUT: begin
                    // Hold the presented coefficient and ask for no new word until accepted.
                    if (bus.coeff_ready) begin
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg     <= idx_reg + IDXW'(1);
                            state_reg   <= REQ;
                            rand_en_reg <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg   <= IDLE;
                    rand_en_reg <= 1'b0;
                    valid_reg   <= 1'b0;
                    last_reg    <= 1'b0;
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rand_en     = rand_en_reg;
    assign bus.coeff       = coeff_reg;
    assign bus.coeff_idx   = idx_reg;
    assign bus.coeff_last  = last_reg;
    assign bus.coeff_valid = valid_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.err         = err_reg;
    assign bus.reject_cnt  = rej_reg;

endmodule
